aes128_arbiter: RTL and testbench

Shares one AES128 encrypt/decrypt core between two requesters. Arbitrates with a round-robin pointer and accepts one operation at a time. Holds the core's operands stable for a fixed core latency, then returns the result to the owning requester over a valid/ready response channel. The latency is chosen per operation: a longer wait when the round key changes, so the core's key expansion can complete.

---
 rtl/aes_arb_pkg.sv | 27 ++
 rtl/aes_arb_rr_arbiter2.sv | 30 +++
 rtl/aes128_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_aes128_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_arb_pkg
// Description : Shared types and constants for the two-requester AES128 core
//               arbiter: FSM state encoding, block width, default core
//               latencies and the owner type.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package aes_arb_pkg;

  localparam int AES_W            = 128;
  localparam int LAT_SAME_KEY_DEF = 12;
  localparam int LAT_NEW_KEY_DEF  = 23;
  localparam int CNT_W_DEF        = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Identifies requester 0 or requester 1.
  typedef logic owner_t;

endpackage : aes_arb_pkg
`default_nettype wire

// File: rtl/aes_arb_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin grant. A lone request wins
//               outright; when both request, the pointer picks the winner.
// Ports       : req   [1:0] in   request lines (bit n = requester n)
//               ptr         in   preferred requester on a tie
//               grant [1:0] out  one-hot grant, zero when nobody requests
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import aes_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/aes128_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aes128_arbiter
// Description : Shares one AES128 encrypt/decrypt core between two
//               requesters. One operation is in flight at a time; operands
//               are held on the core for a fixed latency (longer when the key
//               changes, so key expansion can finish), then the captured
//               result is returned to the owner over a valid/ready channel.
// Ports       : clk, reset (sync, active-low)
//               reqN_valid/ready/dec/data/key   request channel, N = 0,1
//               rspN_valid/ready/data            response channel, N = 0,1
//               core_sel_cypher/message/key      operands to the core
//               core_result                      core output
//               op_count, rekey_count            only with AES_ARB_STATS_EN
// Build macro : AES_ARB_STATS_EN adds saturating 16-bit accept/rekey counters.
// Note        : 128-bit buses are [127:0]; bit 127 carries the first
//               (most significant) bit of the block.
// Revision    : 1.0  initial release
// ============================================================================
module aes128_arbiter
  import aes_arb_pkg::*;
#(
  parameter int LAT_SAME_KEY = LAT_SAME_KEY_DEF,
  parameter int LAT_NEW_KEY  = LAT_NEW_KEY_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_dec,
  input  logic [AES_W-1:0] req0_data,
  input  logic [AES_W-1:0] req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_dec,
  input  logic [AES_W-1:0] req1_data,
  input  logic [AES_W-1:0] req1_key,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [AES_W-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [AES_W-1:0] rsp1_data,
  output logic             core_sel_cypher,
  output logic [AES_W-1:0] core_message,
  output logic [AES_W-1:0] core_key,
`ifdef AES_ARB_STATS_EN
  output logic [15:0]      op_count,
  output logic [15:0]      rekey_count,
`endif
  input  logic [AES_W-1:0] core_result
);

  localparam logic [CNT_W-1:0] CNT_NEW  = CNT_W'(LAT_NEW_KEY);
  localparam logic [CNT_W-1:0] CNT_SAME = CNT_W'(LAT_SAME_KEY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e       state_q, state_d;
  owner_t           ptr_q, ptr_d;
  owner_t           owner_q, owner_d;
  logic             key_valid_q, key_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AES_W-1:0] result_q, result_d;
  logic             sel_q, sel_d;
  logic [AES_W-1:0] msg_q, msg_d;
  // The core key register doubles as the last-issued key: both are loaded
  // with the accepted key and cleared together on reset.
  logic [AES_W-1:0] key_q, key_d;

  logic [1:0]       grant;
  owner_t           winner;
  logic             win_dec;
  logic [AES_W-1:0] win_data;
  logic [AES_W-1:0] win_key;
  logic             new_key;
  logic             accept;
  logic             rsp_fire;

  rr_arbiter2 u_rr (
    .req   ({req1_valid, req0_valid}),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign winner   = grant[1];
  assign win_dec  = winner ? req1_dec  : req0_dec;
  assign win_data = winner ? req1_data : req0_data;
  assign win_key  = winner ? req1_key  : req0_key;
  assign new_key  = !key_valid_q || (win_key != key_q);
  assign accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign rsp_fire = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  // -------------------------------------------------------------------------
  // State register (and all other flops)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      key_valid_q <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      sel_q       <= 1'b0;
      msg_q       <= '0;
      key_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      key_valid_q <= key_valid_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      sel_q       <= sel_d;
      msg_q       <= msg_d;
      key_q       <= key_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == CNT_ONE) state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    key_valid_d = key_valid_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    sel_d       = sel_q;
    msg_d       = msg_q;
    key_d       = key_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d       = win_dec;
          msg_d       = win_data;
          key_d       = win_key;
          owner_d     = winner;
          cnt_d       = new_key ? CNT_NEW : CNT_SAME;
          key_valid_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        // The last wait cycle is when the core output is guaranteed settled.
        if (cnt_q == CNT_ONE) result_d = core_result;
      end
      RESP: begin
        if (rsp_fire) ptr_d = ~owner_q;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // Held low while reset is asserted so no handshake is offered that
        // the reset would then swallow.
        req0_ready = reset & grant[0];
        req1_ready = reset & grant[1];
      end
      RESP: begin
        rsp0_valid = (owner_q == 1'b0);
        rsp1_valid = (owner_q == 1'b1);
      end
      default: begin
      end
    endcase
  end

  assign rsp0_data       = result_q;
  assign rsp1_data       = result_q;
  assign core_sel_cypher = sel_q;
  assign core_message    = msg_q;
  assign core_key        = key_q;

`ifdef AES_ARB_STATS_EN
  logic [15:0] op_cnt_q, op_cnt_d;
  logic [15:0] rekey_cnt_q, rekey_cnt_d;

  always_comb begin
    op_cnt_d    = op_cnt_q;
    rekey_cnt_d = rekey_cnt_q;
    if (accept && op_cnt_q != 16'hFFFF) op_cnt_d = op_cnt_q + 16'd1;
    if (accept && new_key && rekey_cnt_q != 16'hFFFF) rekey_cnt_d = rekey_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_cnt_q    <= '0;
      rekey_cnt_q <= '0;
    end else begin
      op_cnt_q    <= op_cnt_d;
      rekey_cnt_q <= rekey_cnt_d;
    end
  end

  assign op_count    = op_cnt_q;
  assign rekey_count = rekey_cnt_q;
`endif

endmodule : aes128_arbiter
`default_nettype wire

// File: tb/tb_aes128_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes128_arbiter
// Description : Scoreboard bench for aes128_arbiter. Drivers push expected
//               responses (data and arrival cycle) at accept time; a monitor
//               pops and compares whenever a response is presented. The core
//               is a stub that returns FIPS-197 answers for the known vectors,
//               a simple keyed mix otherwise, and inverted data until its
//               inputs have been stable long enough.
// Build macro : AES_ARB_STATS_EN also checks op_count / rekey_count.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes128_arbiter;

  localparam int LAT_SAME = 12;
  localparam int LAT_NEW  = 23;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         r0_valid = 1'b0, r0_dec = 1'b0;
  logic [127:0] r0_data = '0, r0_key = '0;
  logic         r1_valid = 1'b0, r1_dec = 1'b0;
  logic [127:0] r1_data = '0, r1_key = '0;
  logic         rr0 = 1'b0, rr1 = 1'b0;
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [127:0] rsp0_data, rsp1_data;
  logic         core_sel_cypher;
  logic [127:0] core_message, core_key, core_result;
`ifdef AES_ARB_STATS_EN
  logic [15:0]  op_count, rekey_count;
`endif

  aes128_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid      (r0_valid),
    .req0_ready      (req0_ready),
    .req0_dec        (r0_dec),
    .req0_data       (r0_data),
    .req0_key        (r0_key),
    .req1_valid      (r1_valid),
    .req1_ready      (req1_ready),
    .req1_dec        (r1_dec),
    .req1_data       (r1_data),
    .req1_key        (r1_key),
    .rsp0_valid      (rsp0_valid),
    .rsp0_ready      (rr0),
    .rsp0_data       (rsp0_data),
    .rsp1_valid      (rsp1_valid),
    .rsp1_ready      (rr1),
    .rsp1_data       (rsp1_data),
    .core_sel_cypher (core_sel_cypher),
    .core_message    (core_message),
    .core_key        (core_key),
`ifdef AES_ARB_STATS_EN
    .op_count        (op_count),
    .rekey_count     (rekey_count),
`endif
    .core_result     (core_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Stub AES core: true answers for the FIPS-197 vectors, an arbitrary keyed
  // mix for everything else (the arbiter only moves data around).
  function automatic logic [127:0] aes_stub(input logic dec, input logic [127:0] m, input logic [127:0] k);
    if (!dec && k == K1 && m == P1) return C1;
    if ( dec && k == K1 && m == C1) return P1;
    if (!dec && k == K2 && m == P2) return C2;
    if ( dec && k == K2 && m == C2) return P2;
    if (dec) return m ^ {k[15:0], k[127:16]} ^ 128'ha5a5_0f0f_3c3c_5555_aaaa_c3c3_f0f0_5a5a;
    return {m[119:0], m[127:120]} ^ k;
  endfunction

  // Core settling model: inputs must be stable LAT_SAME-1 negedges and the
  // key LAT_NEW-1 negedges before the output is the true result.
  int           in_age = 0;
  int           key_age = 0;
  logic [128:0] prev_in = '0;
  logic [127:0] prev_key = '0;

  always @(negedge clk) begin
    if ({core_sel_cypher, core_message} !== prev_in) in_age <= 0;
    else if (in_age < 1000) in_age <= in_age + 1;
    if (core_key !== prev_key) key_age <= 0;
    else if (key_age < 1000) key_age <= key_age + 1;
    prev_in  <= {core_sel_cypher, core_message};
    prev_key <= core_key;
  end

  always_comb begin
    core_result = aes_stub(core_sel_cypher, core_message, core_key);
    if (in_age < LAT_SAME - 1 || key_age < LAT_NEW - 1) core_result = ~core_result;
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t         q0[$];
  exp_t         q1[$];
  int           acc_log[$];
  bit           m_key_valid = 1'b0;
  logic [127:0] m_last_key = '0;
  int           m_ops = 0;
  int           m_rekeys = 0;
  bit           seen[2];
  logic [127:0] held[2];
  logic [127:0] pool[3];
  int           rsp_mode = 0;

  function automatic int qsize(input int p);
    if (p == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t qfront(input int p);
    if (p == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic void qpop(input int p);
    if (p == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endfunction

  // Called just before the accepting edge; cyc then counts edges so far.
  function automatic void model_accept(input int p, input logic dec, input logic [127:0] data,
                                       input logic [127:0] key);
    exp_t e;
    bit   nk;
    nk     = !m_key_valid || (key != m_last_key);
    e.cyc  = cyc + 1 + (nk ? LAT_NEW : LAT_SAME);
    e.data = aes_stub(dec, data, key);
    m_key_valid = 1'b1;
    m_last_key  = key;
    m_ops++;
    if (nk) m_rekeys++;
    acc_log.push_back(p);
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  task automatic mon_port(input int p);
    logic         v, r;
    logic [127:0] d;
    exp_t         e;
    v = (p == 0) ? rsp0_valid : rsp1_valid;
    r = (p == 0) ? rr0 : rr1;
    d = (p == 0) ? rsp0_data : rsp1_data;
    if (v) begin
      if (qsize(p) == 0) begin
        chk($sformatf("rsp%0d_unexpected_valid", p), 128'(v), 128'(0));
      end else begin
        e = qfront(p);
        if (!seen[p]) begin
          chk($sformatf("rsp%0d_latency_cycle", p), 128'(cyc), 128'(e.cyc));
          chk($sformatf("rsp%0d_data", p), d, e.data);
          seen[p] = 1'b1;
          held[p] = d;
        end else begin
          chk($sformatf("rsp%0d_data_hold", p), d, held[p]);
        end
        if (r) begin
          qpop(p);
          seen[p] = 1'b0;
        end
      end
    end else if (seen[p]) begin
      chk($sformatf("rsp%0d_valid_dropped", p), 128'(v), 128'(1));
      seen[p] = 1'b0;
      qpop(p);
    end else if (qsize(p) > 0) begin
      e = qfront(p);
      if (cyc > e.cyc) begin
        chk($sformatf("rsp%0d_late", p), 128'(v), 128'(1));
        qpop(p);
      end
    end
  endtask

  // Monitor samples 2 time units after each rising edge.
  initial begin
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        if (req0_ready || req1_ready)
          chk("ready_onehot", 128'(req0_ready & req1_ready), 128'(0));
        if (qsize(0) + qsize(1) > 0)
          chk("ready_while_busy", 128'({req0_ready, req1_ready}), 128'(0));
        mon_port(0);
        mon_port(1);
      end
    end
  end

  // Response-ready driver, updated 1 unit after each rising edge so the value
  // the monitor sees is the value at the next edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0: begin rr0 = 1'b1; rr1 = 1'b1; end
        1: begin rr0 = 1'($urandom_range(0, 1)); rr1 = 1'($urandom_range(0, 1)); end
        default: begin rr0 = 1'b0; rr1 = 1'b1; end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic issue(input int p, input logic dec, input logic [127:0] data, input logic [127:0] key);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    if (p == 0) begin r0_valid = 1'b1; r0_dec = dec; r0_data = data; r0_key = key; end
    else        begin r1_valid = 1'b1; r1_dec = dec; r1_data = data; r1_key = key; end
    for (int t = 0; t < 600 && !acc; t++) begin
      #1;
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
        model_accept(p, dec, data, key);
        acc = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk($sformatf("req%0d_accepted", p), 128'(acc), 128'(1));
    @(negedge clk);
    if (p == 0) r0_valid = 1'b0;
    else r1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q0.size() + q1.size()) != 0 && t < 3000) begin
      @(posedge clk);
      #3;
      t++;
    end
    chk("drain_outstanding", 128'(q0.size() + q1.size()), 128'(0));
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    m_key_valid = 1'b0;
    m_ops = 0;
    m_rekeys = 0;
    @(posedge clk);
    #2;
    chk("rst_ready", 128'({req0_ready, req1_ready}), 128'(0));
    chk("rst_rsp_valid", 128'({rsp0_valid, rsp1_valid}), 128'(0));
    chk("rst_core_sel", 128'(core_sel_cypher), 128'(0));
    chk("rst_core_message", core_message, 128'(0));
    chk("rst_core_key", core_key, 128'(0));
    chk("rst_rsp0_data", rsp0_data, 128'(0));
    chk("rst_rsp1_data", rsp1_data, 128'(0));
`ifdef AES_ARB_STATS_EN
    chk("rst_op_count", 128'(op_count), 128'(0));
    chk("rst_rekey_count", 128'(rekey_count), 128'(0));
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic port_rand(input int p);
    logic [127:0] d;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      issue(p, 1'($urandom_range(0, 1)), d, pool[$urandom_range(0, 2)]);
    end
  endtask

  initial begin
    int n;
    pool[0] = K1;
    pool[1] = K2;
    pool[2] = 128'hdeadbeef_01234567_89abcdef_feedface;
    rsp_mode = 0;
    pulse_reset();

    // FIPS-197 encrypt straight after reset: new-key latency.
    issue(0, 1'b0, P1, K1);
    wait_idle();
`ifdef AES_ARB_STATS_EN
    chk("rekey_count_after_first", 128'(rekey_count), 128'(m_rekeys));
`endif

    // Same key, decrypt on the other port: short latency.
    issue(1, 1'b1, C1, K1);
    wait_idle();

    // Simultaneous requests with the pointer at requester 0.
    fork
      issue(0, 1'b0, P2, K1);
      issue(1, 1'b1, C1, K1);
    join
    wait_idle();
    n = acc_log.size();
    chk("tie_first_grant", 128'(acc_log[n-2]), 128'(0));
    chk("tie_second_grant", 128'(acc_log[n-1]), 128'(1));

    // Response backpressure on port 0 while port 1 waits.
    rsp_mode = 2;
    fork
      issue(0, 1'b0, P1, K1);
      begin
        repeat (3) @(negedge clk);
        issue(1, 1'b0, P2, K1);
      end
      begin
        for (int t = 0; t < 100 && !rsp0_valid; t++) @(negedge clk);
        chk("bp_rsp0_seen", 128'(rsp0_valid), 128'(1));
        repeat (10) @(negedge clk);
        rsp_mode = 0;
      end
    join
    wait_idle();

    // Key change, then same key decrypt.
    issue(0, 1'b0, P2, K2);
    wait_idle();
    issue(1, 1'b1, C2, K2);
    wait_idle();

    // Reset during WAIT: in-flight result is dropped, next op sees new-key latency.
    issue(1, 1'b0, P1, K2);
    repeat (5) @(negedge clk);
    pulse_reset();
    issue(0, 1'b0, P2, K2);
    wait_idle();

    // Randomized traffic with random response backpressure.
    rsp_mode = 1;
    fork
      port_rand(0);
      port_rand(1);
    join
    wait_idle();
    rsp_mode = 0;

`ifdef AES_ARB_STATS_EN
    chk("op_count_final", 128'(op_count), 128'(m_ops));
    chk("rekey_count_final", 128'(rekey_count), 128'(m_rekeys));
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d outstanding responses", q0.size() + q1.size());
    $fatal(1, "watchdog");
  end

endmodule : tb_aes128_arbiter
`default_nettype wire
